// File: rtl/quad_encoder_counter.sv
// Quadrature encoder front end: 2-FF sync, glitch filter, x4 decode, 32-bit position.
// Ports: clk, reset (sync, active-high); enc_a/enc_b/enc_z async encoder lines;
//        clear, index_clear_en controls; count, dir, err, index_seen registered outputs.
module quad_encoder_counter #(
    parameter int unsigned FILTER_LEN = 4,
    parameter bit          DIR_INVERT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enc_a,
    input  logic        enc_b,
    input  logic        enc_z,
    input  logic        clear,
    input  logic        index_clear_en,
    output logic [31:0] count,
    output logic        dir,
    output logic        err,
    output logic        index_seen
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    localparam logic [7:0] FLIM = 8'(FILTER_LEN - 1);

    // bit 0 = A, bit 1 = B, bit 2 = Z
    logic [2:0]  sync1_q;
    logic [2:0]  sync2_q;
    logic [2:0]  filt_q;
    logic [2:0]  filt_d;
    logic [2:0]  prev_q;
    logic [2:0]  prev_d;
    logic [7:0]  fcnt_q [3];
    logic [7:0]  fcnt_d [3];
    state_e      state_q;
    state_e      state_d;
    logic [1:0]  init_cnt_q;
    logic [1:0]  init_cnt_d;
    logic [31:0] count_q;
    logic [31:0] count_d;
    logic        dir_q;
    logic        dir_d;
    logic        err_q;
    logic        err_d;
    logic        seen_q;
    logic        seen_d;

    logic [1:0]  prev_ab;
    logic [1:0]  cur_ab;
    logic        fwd;
    logic        rev;
    logic        illegal;
    logic        up;
    logic        z_rise;

    assign prev_ab = {prev_q[0], prev_q[1]};
    assign cur_ab  = {filt_q[0], filt_q[1]};
    assign z_rise  = ~prev_q[2] & filt_q[2];

    // Gray-code step classification on {prev, cur}
    always_comb begin
        fwd     = 1'b0;
        rev     = 1'b0;
        illegal = 1'b0;
        case ({prev_ab, cur_ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: fwd     = 1'b1;
            4'b0010, 4'b1011, 4'b1101, 4'b0100: rev     = 1'b1;
            4'b0011, 4'b1100, 4'b0110, 4'b1001: illegal = 1'b1;
            default: ;
        endcase
    end

    assign up = fwd ^ DIR_INVERT;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        filt_d     = filt_q;
        prev_d     = prev_q;
        fcnt_d     = fcnt_q;
        count_d    = count_q;
        dir_d      = dir_q;
        err_d      = err_q;
        seen_d     = seen_q;

        unique case (state_q)
            ST_INIT: begin
                for (int i = 0; i < 3; i++) begin
                    fcnt_d[i] = '0;
                end
                // Prime filter and history from the live lines so the
                // first RUN cycle sees no transition.
                if (init_cnt_q == 2'd2) begin
                    filt_d  = sync2_q;
                    prev_d  = sync2_q;
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + 2'd1;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < 3; i++) begin
                    if (sync2_q[i] == filt_q[i]) begin
                        fcnt_d[i] = '0;
                    end else if (fcnt_q[i] == FLIM) begin
                        filt_d[i] = sync2_q[i];
                        fcnt_d[i] = '0;
                    end else begin
                        fcnt_d[i] = fcnt_q[i] + 8'd1;
                    end
                end
                prev_d = filt_q;

                if (z_rise && index_clear_en) begin
                    count_d = '0;
                    seen_d  = 1'b1;
                end else if (fwd || rev) begin
                    count_d = up ? count_q + 32'd1 : count_q - 32'd1;
                    dir_d   = up;
                end else if (illegal) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (clear) begin
            count_d = '0;
            err_d   = 1'b0;
            seen_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            filt_q     <= '0;
            prev_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                fcnt_q[i] <= '0;
            end
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            count_q    <= '0;
            dir_q      <= 1'b0;
            err_q      <= 1'b0;
            seen_q     <= 1'b0;
        end else begin
            sync1_q    <= {enc_z, enc_b, enc_a};
            sync2_q    <= sync1_q;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            for (int i = 0; i < 3; i++) begin
                fcnt_q[i] <= fcnt_d[i];
            end
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            count_q    <= count_d;
            dir_q      <= dir_d;
            err_q      <= err_d;
            seen_q     <= seen_d;
        end
    end

    assign count      = count_q;
    assign dir        = dir_q;
    assign err        = err_q;
    assign index_seen = seen_q;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// Self-checking bench for quad_encoder_counter against a position-level model.
// Two instances share the encoder lines: normal sense and DIR_INVERT = 1.
module tb_quad_encoder_counter;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enc_a;
    logic        enc_b;
    logic        enc_z;
    logic        clear;
    logic        ice;
    logic [31:0] count0;
    logic [31:0] count1;
    logic        dir0;
    logic        dir1;
    logic        err0;
    logic        err1;
    logic        seen0;
    logic        seen1;

    quad_encoder_counter #(.FILTER_LEN(L), .DIR_INVERT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .enc_z(enc_z), .clear(clear), .index_clear_en(ice),
        .count(count0), .dir(dir0), .err(err0), .index_seen(seen0)
    );

    quad_encoder_counter #(.FILTER_LEN(L), .DIR_INVERT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .enc_z(enc_z), .clear(clear), .index_clear_en(ice),
        .count(count1), .dir(dir1), .err(err1), .index_seen(seen1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: quadrature position of the lines plus the expected outputs.
    logic [1:0]  m_ab;
    logic [31:0] m_cnt;
    logic        m_dir;
    logic        m_dir1;
    logic        m_err;
    logic        m_seen;
    logic [1:0]  seq [4];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pos(input logic [1:0] ab);
        for (int i = 0; i < 4; i++) begin
            if (seq[i] == ab) return i;
        end
        return 0;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle();
        tick(L + 5);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".cnt0"}, count0, m_cnt);
        chk({tag, ".cnt1"}, count1, 32'd0 - m_cnt);
        chk({tag, ".dir0"}, {31'd0, dir0}, {31'd0, m_dir});
        chk({tag, ".dir1"}, {31'd0, dir1}, {31'd0, m_dir1});
        chk({tag, ".err0"}, {31'd0, err0}, {31'd0, m_err});
        chk({tag, ".err1"}, {31'd0, err1}, {31'd0, m_err});
        chk({tag, ".seen0"}, {31'd0, seen0}, {31'd0, m_seen});
        chk({tag, ".seen1"}, {31'd0, seen1}, {31'd0, m_seen});
    endtask

    // Drive new A/B (and optionally raise Z) and update the model.
    task automatic drive(input logic [1:0] ab, input bit zrise);
        int d;
        d = (pos(ab) - pos(m_ab) + 4) % 4;
        enc_a = ab[1];
        enc_b = ab[0];
        if (zrise) enc_z = 1'b1;
        if (zrise && ice) begin
            m_cnt  = 32'd0;
            m_seen = 1'b1;
        end else if (d == 1) begin
            m_cnt  = m_cnt + 32'd1;
            m_dir  = 1'b1;
            m_dir1 = 1'b0;
        end else if (d == 3) begin
            m_cnt  = m_cnt - 32'd1;
            m_dir  = 1'b0;
            m_dir1 = 1'b1;
        end else if (d == 2) begin
            m_err = 1'b1;
        end
        m_ab = ab;
    endtask

    // d: 1 forward, 3 reverse, 2 illegal, 0 none
    task automatic move(input int d, input bit zrise);
        drive(seq[(pos(m_ab) + d) % 4], zrise);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        m_cnt  = 32'd0;
        m_err  = 1'b0;
        m_seen = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int r;
        int len;
        logic [31:0] old;
        logic [1:0]  ab0;

        seq    = '{2'b00, 2'b01, 2'b11, 2'b10};
        reset  = 1'b1;
        enc_a  = 1'b1;
        enc_b  = 1'b1;
        enc_z  = 1'b0;
        clear  = 1'b0;
        ice    = 1'b0;
        m_ab   = 2'b11;
        m_cnt  = 32'd0;
        m_dir  = 1'b0;
        m_dir1 = 1'b0;
        m_err  = 1'b0;
        m_seen = 1'b0;
        tick(3);
        check_all("reset");
        reset = 1'b0;
        tick(L + 8);
        check_all("prime");

        repeat (32) begin
            move(1, 1'b0);
            tick(10);
        end
        check_all("fwd32");
        chk("fwd32.const", count0, 32'd32);
        repeat (40) begin
            move(3, 1'b0);
            tick(10);
        end
        check_all("rev40");
        chk("rev40.const", count0, 32'hFFFF_FFF8);

        old = count0;
        move(1, 1'b0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (count0 !== old) begin
                lat = i;
                break;
            end
        end
        chk("latency", 32'(lat), 32'(L + 3));
        settle();
        check_all("lat.after");

        pulse_clear();
        enc_a = ~enc_a;
        tick(3);
        enc_a = ~enc_a;
        settle();
        check_all("glitch3");

        ab0 = m_ab;
        drive({~ab0[1], ab0[0]}, 1'b0);
        tick(4);
        enc_a = ab0[1];
        tick(4);
        check_all("pulse4.mid");
        drive(ab0, 1'b0);
        settle();
        check_all("pulse4.end");
        chk("pulse4.zero", count0, 32'd0);

        move(2, 1'b0);
        settle();
        check_all("illegal");
        pulse_clear();
        check_all("clear");

        move(3, 1'b0);
        settle();
        chk("wrap.neg", count0, 32'hFFFF_FFFF);
        move(1, 1'b0);
        settle();
        chk("wrap.pos", count0, 32'd0);
        move(3, 1'b0);
        settle();
        check_all("wrap");

        pulse_clear();
        repeat (5) begin
            move(3, 1'b0);
            tick(10);
        end
        move(1, 1'b0);
        settle();
        chk("inv.cnt", count1, 32'd4);
        chk("inv.dir", {31'd0, dir1}, 32'd0);
        check_all("inv");

        pulse_clear();
        repeat (100) begin
            move(1, 1'b0);
            tick(6);
        end
        settle();
        chk("idx.pre", count0, 32'd100);
        ice = 1'b1;
        move(1, 1'b1);
        settle();
        chk("idx.cnt", count0, 32'd0);
        chk("idx.seen", {31'd0, seen0}, 32'd1);
        check_all("idx");
        enc_z = 1'b0;
        settle();
        repeat (100) begin
            move(1, 1'b0);
            tick(6);
        end
        ice = 1'b0;
        move(1, 1'b1);
        settle();
        chk("noidx.cnt", count0, 32'd101);
        check_all("noidx");
        enc_z = 1'b0;
        settle();

        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) begin
                move(1, 1'b0);
            end else if (r <= 5) begin
                move(3, 1'b0);
            end else if (r == 6) begin
                move(2, 1'b0);
            end else if (r == 7) begin
                len = $urandom_range(1, L - 1);
                if ($urandom_range(0, 1) == 1) begin
                    enc_a = ~enc_a;
                    tick(len);
                    enc_a = ~enc_a;
                end else begin
                    enc_b = ~enc_b;
                    tick(len);
                    enc_b = ~enc_b;
                end
            end else if (r == 8) begin
                pulse_clear();
            end else begin
                ice = 1'($urandom_range(0, 1));
                move(2 * $urandom_range(0, 1) + $urandom_range(0, 1) * 1 == 2 ? 1 : 3, 1'b1);
                settle();
                enc_z = 1'b0;
            end
            tick($urandom_range(L + 5, L + 10));
            check_all("rand");
        end

        move(1, 1'b0);
        settle();
        reset = 1'b1;
        ab0 = {~m_ab[1], ~m_ab[0]};
        enc_a = ab0[1];
        enc_b = ab0[0];
        m_ab   = ab0;
        m_cnt  = 32'd0;
        m_dir  = 1'b0;
        m_dir1 = 1'b0;
        m_err  = 1'b0;
        m_seen = 1'b0;
        tick(1);
        check_all("midrst");
        reset = 1'b0;
        tick(L + 8);
        check_all("reprime");
        move(1, 1'b0);
        settle();
        check_all("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
